// File: rtl/stream_demux_1to4.sv
// 1-to-4 packet demultiplexer with per-channel 1-entry output buffers and packet-locked routing.
// Define DEMUX_CNT_EN to add saturating per-channel packet counters on port pkt_cnt.
module stream_demux_1to4 #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       s,
  output logic [4*W-1:0]   out_data,
  output logic [3:0]       out_last,
  output logic [3:0]       out_valid,
`ifdef DEMUX_CNT_EN
  output logic [4*CNT_W-1:0] pkt_cnt,
`endif
  input  logic [3:0]       out_ready
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q;
  logic [1:0] cur_sel_q;
  logic [1:0] ch;
  logic       accept;

  // The select is only honoured on a packet's first beat.
  always_comb begin
    ch       = (state_q == StIdle) ? s : cur_sel_q;
    in_ready = !out_valid[ch] | out_ready[ch];
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_sel_q <= 2'd0;
      out_valid <= 4'b0000;
      out_last  <= 4'b0000;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (ch == 2'(k))) begin
          out_valid[k]       <= 1'b1;
          out_last[k]        <= in_last;
          out_data[k*W +: W] <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (!in_last) begin
              state_q   <= StBusy;
              cur_sel_q <= s;
            end
          end
          StBusy: begin
            if (in_last) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && in_last && (ch == 2'(k)) && (pkt_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          pkt_cnt[k*CNT_W +: CNT_W] <= pkt_cnt[k*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Directed self-checking bench for stream_demux_1to4: routing, locking, backpressure, reset.
module tb_stream_demux_1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  s;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0]  pkt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_demux_1to4 #(.W(8), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
`ifdef DEMUX_CNT_EN
    .pkt_cnt   (pkt_cnt),
`endif
    .out_ready (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; s = 2'd0; out_ready = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_tests++;
    if (out_last !== 4'b0000) begin n_fail++; $display("FAIL reset_last got %b want 0000", out_last); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_beat();
    out_ready = 4'b1111; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i); in_data = 8'(8'h11 * (i + 1));
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 4'(1 << i)) begin
        n_fail++; $display("FAIL single_valid[%0d] got %b want %b", i, out_valid, 4'(1 << i));
      end
      n_tests++;
      if (out_data[i*8 +: 8] !== 8'(8'h11 * (i + 1))) begin
        n_fail++; $display("FAIL single_data[%0d] got %h want %h", i, out_data[i*8 +: 8], 8'(8'h11 * (i + 1)));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_lock();
    logic [7:0] d [3] = '{8'hA0, 8'hA1, 8'hA2};
    out_ready = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = (i == 0) ? 2'd2 : 2'd0; in_data = d[i]; in_last = (i == 2);
      tick();
      n_tests++;
      if (out_valid !== 4'b0100 || out_data[23:16] !== d[i] || out_last[2] !== (i == 2)) begin
        n_fail++;
        $display("FAIL lock_beat[%0d] got v=%b d=%h l=%b want v=0100 d=%h l=%b",
                 i, out_valid, out_data[23:16], out_last[2], d[i], (i == 2));
      end
    end
    s = 2'd0; in_data = 8'hB0; in_last = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hB0) begin
      n_fail++; $display("FAIL lock_next got v=%b d=%h want v=0001 d=b0", out_valid, out_data[7:0]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101; in_valid = 1'b1; s = 2'd1; in_data = 8'h51; in_last = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h51) begin
      n_fail++; $display("FAIL bp_first got v=%b d=%h want v=0010 d=51", out_valid, out_data[15:8]);
    end
    in_data = 8'h52; in_last = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h51 || out_last[1] !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got v=%b d=%h l=%b want v=0010 d=51 l=0",
                         out_valid, out_data[15:8], out_last[1]);
    end
    out_ready = 4'b1111;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_tests++;
    if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h52 || out_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got v=%b d=%h l=%b want v=0010 d=52 l=1",
                         out_valid, out_data[15:8], out_last[1]);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_done got v=%b r=%b want v=0000 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b1111; in_valid = 1'b1; s = 2'd3;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hD0 + i); in_last = (i == 3);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 4'b1000 || out_data[31:24] !== 8'(8'hD0 + i) || out_last[3] !== (i == 3)) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d] got v=%b d=%h l=%b want v=1000 d=%h l=%b",
                 i, out_valid, out_data[31:24], out_last[3], 8'(8'hD0 + i), (i == 3));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL b2b_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 4'b0000; in_valid = 1'b1; s = 2'd1; in_data = 8'h61; in_last = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL rmid_first got %b want 0010", out_valid); end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL rmid_flush got v=%b d=%h want v=0000 d=0", out_valid, out_data);
    end
    out_ready = 4'b1111; in_valid = 1'b1; s = 2'd0; in_data = 8'h62; in_last = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h62) begin
      n_fail++; $display("FAIL rmid_next got v=%b d=%h want v=0001 d=62", out_valid, out_data[7:0]);
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 4'b1111; in_valid = 1'b1; s = 2'd0; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i);
      tick();
      if (i == 1) begin
        n_tests++;
        if (pkt_cnt !== 8'h02) begin n_fail++; $display("FAIL cnt_two got %h want 02", pkt_cnt); end
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (pkt_cnt !== 8'h03) begin n_fail++; $display("FAIL cnt_sat got %h want 03", pkt_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_beat();
    test_lock();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
